// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and a shift-add multiplier.
// Latency: 1 clock for single-cycle ops, WIDTH+1 clocks for MUL.
// Backpressure: a held result blocks new operands; in_ready is low while MUL runs.
module alu_seq #(
    parameter  int WIDTH = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_INC  = 4'hB;
    localparam logic [3:0] OP_DEC  = 4'hC;
    localparam logic [3:0] OP_PASS = 4'hD;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [3:0]           flags_q, flags_d;
    logic                 err_q, err_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [SHW-1:0]       cnt_q, cnt_d;

    logic                 accept;
    logic [SHW-1:0]       sh;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     r_x, r_y;
    logic                 r_c, r_v, r_err;
    logic [WIDTH:0]       mul_hi;
    logic [2*WIDTH-1:0]   mul_nxt;

    // Reset gating keeps the source from seeing ready while the block is held in reset.
    assign in_ready  = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign sh        = b[SHW-1:0];

    assign out_valid = out_valid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign flags     = flags_q;
    assign err       = err_q;

    always_comb begin
        opnd  = (opcode == OP_INC || opcode == OP_DEC) ? ONE : b;
        sum   = {1'b0, a} + {1'b0, opnd};
        diff  = {1'b0, a} - {1'b0, opnd};
        r_x   = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        r_err = 1'b0;
        case (opcode)
            OP_ADD, OP_INC: begin
                r_x = sum[WIDTH-1:0];
                r_c = sum[WIDTH];
                r_v = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                r_x = diff[WIDTH-1:0];
                r_c = diff[WIDTH];
                r_v = (a[WIDTH-1] != opnd[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r_x = a & b;
            OP_OR:   r_x = a | b;
            OP_XOR:  r_x = a ^ b;
            OP_NOT:  r_x = ~a;
            OP_SHL:  r_x = a << sh;
            OP_SHR:  r_x = a >> sh;
            OP_SRA:  r_x = $signed(a) >>> sh;
            OP_SLTU: r_x[0] = (a < b);
            OP_PASS: r_x = a;
            OP_MUL:  r_x = '0;
            default: r_err = 1'b1;
        endcase
        r_y    = '0;
        r_y[0] = r_c;
    end

    // One multiplier bit per clock: add into the high half, then shift the product right.
    always_comb begin
        mul_hi  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_nxt = {mul_hi, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        x_d         = x_q;
        y_d         = y_q;
        flags_d     = flags_q;
        err_d       = err_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        state_d = S_MUL;
                        prod_d  = {{WIDTH{1'b0}}, b};
                        mcand_d = a;
                        cnt_d   = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        x_d         = r_x;
                        y_d         = r_y;
                        flags_d     = r_err ? 4'b0 : {r_c, (r_x == '0), r_x[WIDTH-1], r_v};
                        err_d       = r_err;
                    end
                end
            end
            S_MUL: begin
                prod_d = mul_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    x_d         = mul_nxt[WIDTH-1:0];
                    y_d         = mul_nxt[2*WIDTH-1:WIDTH];
                    flags_d     = {(mul_nxt[2*WIDTH-1:WIDTH] != '0), (mul_nxt[WIDTH-1:0] == '0),
                                   mul_nxt[WIDTH-1], 1'b0};
                    err_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            prod_q      <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
